// File: rtl/cipher_core_param.sv
// cipher_core_param: byte-serial load, iterated XOR/rotate cipher with a valid/ready result port.
//
// Ports:
//   clka       sole clock, rising edge
//   restart    synchronous active-high reset, overrides every other input
//   enable     global advance enable; low freezes all state and blocks both handshakes
//   encode     1 = encode, 0 = decode; captured on the first accepted beat of a word
//   in_valid   byte beat valid
//   in_ready   block can accept a byte beat (IDLE or LOAD, and enabled)
//   d_in       data byte, MSB first
//   key_in     key byte, MSB first
//   out_valid  result available (DONE)
//   out_ready  consumer accepts the result
//   data_out   cipher result, updated on entry to DONE only
//   key_out    loaded base key, updated on entry to DONE only
//   state      FSM state code (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
//   busy       high in LOAD or RUN
module cipher_core_param #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ROUNDS = 4,
   parameter int unsigned ROT    = 3
) (
   input  logic             clka,
   input  logic             restart,
   input  logic             enable,
   input  logic             encode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       d_in,
   input  logic [7:0]       key_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] key_out,
   output logic [2:0]       state,
   output logic             busy
);

   localparam int unsigned BYTES   = WIDTH / 8;
   localparam int unsigned BW      = $clog2(BYTES + 1);
   localparam int unsigned RW      = $clog2(ROUNDS + 1);
   localparam int unsigned DEC_ROT = (ROUNDS - 1) % WIDTH;

   localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES - 1);
   localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StRun  = 3'd2,
      StDone = 3'd3
   } state_e;

   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned n);
      int unsigned s;
      s = n % WIDTH;
      if (s == 0) return v;
      return (v << s) | (v >> (WIDTH - s));
   endfunction

   function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int unsigned n);
      int unsigned s;
      s = n % WIDTH;
      if (s == 0) return v;
      return (v >> s) | (v << (WIDTH - s));
   endfunction

   // Decode walks the encode schedule backwards, so it starts at the last encode round key.
   function automatic logic [WIDTH-1:0] first_rkey(input logic [WIDTH-1:0] k, input logic enc);
      return enc ? k : rotl(k, DEC_ROT);
   endfunction

   state_e          state_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] key_q;
   logic [WIDTH-1:0] rkey_q;
   logic             mode_q;
   logic [BW-1:0]    byte_cnt_q;
   logic [RW-1:0]    round_cnt_q;

   logic             beat;
   logic [WIDTH-1:0] data_shift;
   logic [WIDTH-1:0] key_shift;
   logic [WIDTH-1:0] round_data;

   always_comb begin
      in_ready   = enable & ((state_q == StIdle) | (state_q == StLoad));
      beat       = in_valid & in_ready;
      data_shift = {data_q[WIDTH-9:0], d_in};
      key_shift  = {key_q[WIDTH-9:0], key_in};
      round_data = mode_q ? rotl(data_q ^ rkey_q, ROT) : (rotr(data_q, ROT) ^ rkey_q);
      busy       = (state_q == StLoad) | (state_q == StRun);
      state      = state_q;
   end

   always_ff @(posedge clka) begin
      if (restart) begin
         state_q     <= StIdle;
         data_q      <= '0;
         key_q       <= '0;
         rkey_q      <= '0;
         mode_q      <= 1'b0;
         byte_cnt_q  <= '0;
         round_cnt_q <= '0;
         data_out    <= '0;
         key_out     <= '0;
         out_valid   <= 1'b0;
      end else if (enable) begin
         case (state_q)
            StIdle: begin
               if (beat) begin
                  data_q <= data_shift;
                  key_q  <= key_shift;
                  mode_q <= encode;
                  if (BYTES > 1) begin
                     byte_cnt_q <= BW'(1);
                     state_q    <= StLoad;
                  end else begin
                     byte_cnt_q <= '0;
                     rkey_q     <= first_rkey(key_shift, encode);
                     state_q    <= StRun;
                  end
               end
            end
            StLoad: begin
               if (beat) begin
                  data_q <= data_shift;
                  key_q  <= key_shift;
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_q <= '0;
                     rkey_q     <= first_rkey(key_shift, mode_q);
                     state_q    <= StRun;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + BW'(1);
                  end
               end
            end
            StRun: begin
               // ROUNDS round cycles, then one cycle that publishes the result.
               if (round_cnt_q == LAST_ROUND) begin
                  round_cnt_q <= '0;
                  data_out    <= data_q;
                  key_out     <= key_q;
                  out_valid   <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  data_q      <= round_data;
                  rkey_q      <= mode_q ? rotl(rkey_q, 1) : rotr(rkey_q, 1);
                  round_cnt_q <= round_cnt_q + RW'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid   <= 1'b0;
               byte_cnt_q  <= '0;
               round_cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cipher_core_param.sv
module tb_cipher_core_param;

   logic        clka = 1'b0;
   logic        restart, enable, encode, in_valid, in_ready;
   logic [7:0]  d_in, key_in;
   logic        out_valid, out_ready, busy;
   logic [15:0] data_out, key_out;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int cyc    = 0;
   int t_accept = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [15:0] k;
   } exp_t;
   exp_t sb[$];

   cipher_core_param #(.WIDTH(16), .ROUNDS(2), .ROT(3)) dut (
      .clka      (clka),
      .restart   (restart),
      .enable    (enable),
      .encode    (encode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d_in      (d_in),
      .key_in    (key_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .key_out   (key_out),
      .state     (state),
      .busy      (busy)
   );

   always #5 clka = ~clka;
   always @(posedge clka) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected result whenever a handshake is about to complete.
   always @(negedge clka) begin
      exp_t e;
      if (!restart && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid actual=%0h expected=no result", data_out);
         end else if (out_ready && enable) begin
            e = sb.pop_front();
            pops++;
            check("result_data", {16'h0, data_out}, {16'h0, e.d});
            check("result_key", {16'h0, key_out}, {16'h0, e.k});
         end
      end
   end

   // Two beats, MSB first; encode is inverted on the second beat and must be ignored.
   task automatic send(input logic [15:0] d, input logic [15:0] k, input logic enc,
                       input int gap);
      bit acc;
      for (int b = 0; b < 2; b++) begin
         if (b > 0) begin
            for (int g = 0; g < gap; g++) begin
               in_valid = 1'b0;
               @(posedge clka); #1;
            end
         end
         in_valid = 1'b1;
         d_in     = (b == 0) ? d[15:8] : d[7:0];
         key_in   = (b == 0) ? k[15:8] : k[7:0];
         encode   = (b == 0) ? enc : ~enc;
         acc = 1'b0;
         for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge clka);
            acc = in_ready;
            @(posedge clka); #1;
         end
         if (!acc) check("accept_timeout", 32'd0, 32'd1);
         if (b == 0) begin
            check("load_state", {29'h0, state}, 32'd1);
            check("load_busy", {31'h0, busy}, 32'd1);
         end
      end
      in_valid = 1'b0;
      t_accept = cyc;
   endtask

   task automatic wait_valid(input string name, input int exp_lat);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clka);
         if (out_valid) found = 1'b1;
      end
      if (!found) check({name, "_valid_timeout"}, 32'd0, 32'd1);
      else check({name, "_latency"}, cyc - t_accept, exp_lat);
   endtask

   task automatic wait_handshake(input string name);
      bit gone;
      gone = 1'b0;
      for (int i = 0; i < 30 && !gone; i++) begin
         @(negedge clka);
         if (!out_valid) gone = 1'b1;
      end
      if (!gone) check({name, "_handshake_timeout"}, 32'd0, 32'd1);
      @(posedge clka); #1;
   endtask

   initial begin
      restart   = 1'b1;
      enable    = 1'b1;
      in_valid  = 1'b1;
      encode    = 1'b1;
      d_in      = 8'hAA;
      key_in    = 8'h55;
      out_ready = 1'b0;

      // Reset held two edges with in_valid high.
      repeat (2) @(posedge clka);
      #1;
      check("rst_state", {29'h0, state}, 32'd0);
      check("rst_out_valid", {31'h0, out_valid}, 32'd0);
      check("rst_data_out", {16'h0, data_out}, 32'd0);
      check("rst_key_out", {16'h0, key_out}, 32'd0);
      check("rst_in_ready", {31'h0, in_ready}, 32'd1);
      check("rst_busy", {31'h0, busy}, 32'd0);
      restart  = 1'b0;
      in_valid = 1'b0;
      @(posedge clka); #1;

      // Encode 0x1234 / 0x00FF -> 0xBD34.
      out_ready = 1'b1;
      send(16'h1234, 16'h00FF, 1'b1, 0);
      sb.push_back('{d: 16'hBD34, k: 16'h00FF});
      wait_valid("enc1", 3);
      wait_handshake("enc1");

      // Decode 0xBD34 / 0x00FF -> 0x1234.
      send(16'hBD34, 16'h00FF, 1'b0, 0);
      sb.push_back('{d: 16'h1234, k: 16'h00FF});
      wait_valid("dec1", 3);
      wait_handshake("dec1");

      // Round trip 0xA5C3 / 0x1F2E, result held in DONE with out_ready low.
      out_ready = 1'b0;
      send(16'hA5C3, 16'h1F2E, 1'b1, 0);
      sb.push_back('{d: 16'h498F, k: 16'h1F2E});
      wait_valid("enc2", 3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clka);
         check("hold_out_valid", {31'h0, out_valid}, 32'd1);
         check("hold_data_out", {16'h0, data_out}, 32'h498F);
      end
      @(posedge clka); #1;
      out_ready = 1'b1;
      wait_handshake("enc2");
      send(16'h498F, 16'h1F2E, 1'b0, 0);
      sb.push_back('{d: 16'hA5C3, k: 16'h1F2E});
      wait_valid("dec2", 3);
      wait_handshake("dec2");

      // enable low blocks input acceptance in IDLE.
      enable = 1'b0;
      @(negedge clka);
      check("disabled_in_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clka); #1;
      enable = 1'b1;

      // Input gap in LOAD plus three disabled cycles in RUN.
      send(16'h1234, 16'h00FF, 1'b1, 3);
      sb.push_back('{d: 16'hBD34, k: 16'h00FF});
      @(posedge clka); #1;
      enable = 1'b0;
      repeat (3) @(posedge clka);
      #1;
      check("stall_state", {29'h0, state}, 32'd2);
      enable = 1'b1;
      wait_valid("stall", 6);
      wait_handshake("stall");

      // Restart mid-RUN: the aborted word must never produce a result.
      send(16'h5555, 16'h1111, 1'b1, 0);
      @(posedge clka); #1;
      restart = 1'b1;
      @(posedge clka); #1;
      restart = 1'b0;
      check("abort_state", {29'h0, state}, 32'd0);
      check("abort_out_valid", {31'h0, out_valid}, 32'd0);
      check("abort_busy", {31'h0, busy}, 32'd0);
      repeat (6) @(posedge clka);
      #1;
      send(16'h1234, 16'h00FF, 1'b1, 0);
      sb.push_back('{d: 16'hBD34, k: 16'h00FF});
      wait_valid("fresh", 3);
      wait_handshake("fresh");

      repeat (4) @(posedge clka);
      #1;
      check("sb_empty", sb.size(), 32'd0);
      check("results_seen", pops, 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
